// File: rtl/dcache_axi_bridge.sv
// Bridges the dcache cmd/rsp port to single-beat AXI4 reads and writes, one transaction in flight.
// Zero-wait slave: accept at edge N, rsp_valid sampled high at edge N+3; cmd_ready low while busy.
module dcache_axi_bridge #(
    parameter int         ADDR_WIDTH = 64,
    parameter int         DATA_WIDTH = 64,
    parameter logic [3:0] AXI_ID     = 4'd0,
    localparam int        STRB       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_payload_addr,
    input  logic                  cmd_payload_wen,
    input  logic [DATA_WIDTH-1:0] cmd_payload_wdata,
    input  logic [STRB-1:0]       cmd_payload_wstrb,
    input  logic [2:0]            cmd_payload_size,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_payload_data,
    output logic                  rsp_payload_error,

    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [2:0]            axi_arsize,
    output logic [3:0]            axi_arid,

    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,

    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic [2:0]            axi_awsize,
    output logic [3:0]            axi_awid,

    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic [STRB-1:0]       axi_wstrb,
    output logic                  axi_wlast,

    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    input  logic [1:0]            axi_bresp
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB-1:0]       wstrb_q;
    logic [2:0]            size_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q;
    logic                  accept;

    // Single-beat transfers: the low resp bit and rlast carry no information here.
    logic unused_ok;
    assign unused_ok = ^{axi_rresp[0], axi_rlast, axi_bresp[0]};

    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        state_d   = state_q;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_payload_wen ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (axi_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi_rvalid) begin
                    state_d = RSP;
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in either order or together.
                aw_done_d = aw_done_q | axi_awready;
                w_done_d  = w_done_q  | axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                if (axi_bvalid) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            size_q  <= '0;
        end else if (accept) begin
            addr_q  <= cmd_payload_addr;
            wdata_q <= cmd_payload_wdata;
            wstrb_q <= cmd_payload_wstrb;
            size_q  <= cmd_payload_size;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (state_q == RD_DATA && axi_rvalid) begin
            rsp_data_q <= axi_rdata;
            rsp_err_q  <= axi_rresp[1];
        end else if (state_q == WR_RESP && axi_bvalid) begin
            rsp_data_q <= '0;
            rsp_err_q  <= axi_bresp[1];
        end
    end

    // Every handshake output decodes straight from state, so reset drops them without a clock.
    assign cmd_ready         = (state_q == IDLE);
    assign rsp_valid         = (state_q == RSP);
    assign rsp_payload_data  = rsp_data_q;
    assign rsp_payload_error = rsp_err_q;

    assign axi_arvalid = (state_q == RD_ADDR);
    assign axi_araddr  = addr_q;
    assign axi_arsize  = size_q;
    assign axi_arid    = AXI_ID;
    assign axi_rready  = (state_q == RD_DATA);

    assign axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign axi_awaddr  = addr_q;
    assign axi_awsize  = size_q;
    assign axi_awid    = AXI_ID;

    assign axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wlast   = 1'b1;
    assign axi_bready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: hand-driven AXI slave, response scoreboard queue.
module tb_dcache_axi_bridge;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_payload_addr;
    logic        cmd_payload_wen;
    logic [63:0] cmd_payload_wdata;
    logic [7:0]  cmd_payload_wstrb;
    logic [2:0]  cmd_payload_size;
    logic        rsp_valid;
    logic [63:0] rsp_payload_data;
    logic        rsp_payload_error;
    logic        axi_arvalid, axi_arready;
    logic [63:0] axi_araddr;
    logic [2:0]  axi_arsize;
    logic [3:0]  axi_arid;
    logic        axi_rvalid, axi_rready;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_awvalid, axi_awready;
    logic [63:0] axi_awaddr;
    logic [2:0]  axi_awsize;
    logic [3:0]  axi_awid;
    logic        axi_wvalid, axi_wready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;

    dcache_axi_bridge #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_addr(cmd_payload_addr), .cmd_payload_wen(cmd_payload_wen),
        .cmd_payload_wdata(cmd_payload_wdata), .cmd_payload_wstrb(cmd_payload_wstrb),
        .cmd_payload_size(cmd_payload_size),
        .rsp_valid(rsp_valid), .rsp_payload_data(rsp_payload_data),
        .rsp_payload_error(rsp_payload_error),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arsize(axi_arsize), .axi_arid(axi_arid),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awsize(axi_awsize), .axi_awid(axi_awid),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   ar_hs = 0, aw_hs = 0, w_hs = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are counted just before the edge that completes them.
    task automatic tick();
        if (axi_arvalid && axi_arready) ar_hs++;
        if (axi_awvalid && axi_awready) aw_hs++;
        if (axi_wvalid && axi_wready) w_hs++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [63:0] a, input logic w, input logic [63:0] d,
                         input logic [7:0] s, input logic [2:0] sz);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_payload_addr = a;
        cmd_payload_wen = w;
        cmd_payload_wdata = d;
        cmd_payload_wstrb = s;
        cmd_payload_size = sz;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", cmd_ready, 1);
        tick();
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    // Waits for the pulse, scores it, then confirms it lasted one cycle and the port reopened.
    task automatic wait_rsp(input string tag, output int seen_cyc);
        int   n = 0;
        exp_t e;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        seen_cyc = cyc;
        check({tag, "_rsp_seen"}, rsp_valid, 1);
        if (rsp_valid) begin
            check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_data"}, rsp_payload_data, e.data);
                check({tag, "_err"}, rsp_payload_error, e.err);
            end
            check({tag, "_busy_in_rsp"}, cmd_ready, 0);
            tick();
            check({tag, "_one_pulse"}, rsp_valid, 0);
            check({tag, "_ready_after"}, cmd_ready, 1);
        end
    endtask

    task automatic read_zero_wait(input string tag, input logic [63:0] a, input logic [63:0] d);
        int seen;
        sb.push_back('{data: d, err: 1'b0});
        issue(a, 1'b0, 64'h0, 8'h00, 3'd3);
        check({tag, "_araddr"}, axi_araddr, a);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        axi_rvalid = 1'b1;
        axi_rdata = d;
        axi_rresp = 2'b00;
        tick();
        axi_rvalid = 1'b0;
        wait_rsp(tag, seen);
    endtask

    initial begin
        int seen;
        int aw0, w0, ar0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_payload_addr = '0;
        cmd_payload_wen = 1'b0;
        cmd_payload_wdata = '0;
        cmd_payload_wstrb = '0;
        cmd_payload_size = '0;
        axi_arready = 1'b0;
        axi_rvalid = 1'b0;
        axi_rdata = '0;
        axi_rresp = '0;
        axi_rlast = 1'b1;
        axi_awready = 1'b0;
        axi_wready = 1'b0;
        axi_bvalid = 1'b0;
        axi_bresp = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {axi_arvalid, axi_awvalid, axi_wvalid, rsp_valid}, 0);
        check("rst_readies", {axi_rready, axi_bready}, 0);
        check("rst_rsp_data", rsp_payload_data, 0);
        check("rst_rsp_err", rsp_payload_error, 0);
        check("rst_latched", {axi_awaddr[31:0], axi_wdata[31:0]}, 0);
        check("rst_latched_strb_size", {axi_wstrb, axi_arsize}, 0);
        rst_n = 1'b1;
        tick();

        // 1: zero-wait read
        sb.push_back('{data: 64'h1122334455667788, err: 1'b0});
        issue(64'h8000_0010, 1'b0, 64'h0, 8'h00, 3'd3);
        check("t1_arvalid", axi_arvalid, 1);
        check("t1_araddr", axi_araddr, 64'h8000_0010);
        check("t1_arsize", axi_arsize, 3);
        check("t1_arid", axi_arid, 0);
        check("t1_busy", cmd_ready, 0);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        check("t1_rready", axi_rready, 1);
        check("t1_ar_dropped", axi_arvalid, 0);
        axi_rvalid = 1'b1;
        axi_rdata = 64'h1122334455667788;
        axi_rresp = 2'b00;
        tick();
        axi_rvalid = 1'b0;
        axi_rdata = '0;
        wait_rsp("t1", seen);
        // latency in edges: accept edge to the edge that samples rsp_valid high
        check("t1_latency", 64'(seen - acc_cyc + 1), 3);
        check("t1_rsp_hold", rsp_payload_data, 64'h1122334455667788);

        // 2: write, AW accepted first, W held off for four cycles
        aw0 = aw_hs;
        w0 = w_hs;
        issue(64'h8000_0008, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'h0F, 3'd3);
        check("t2_awid", axi_awid, 0);
        check("t2_awsize", axi_awsize, 3);
        for (int i = 0; i < 5; i++) begin
            axi_awready = (i == 0);
            axi_wready = (i == 4);
            check("t2_awvalid", axi_awvalid, (i == 0) ? 1 : 0);
            check("t2_wvalid", axi_wvalid, 1);
            check("t2_awaddr", axi_awaddr, 64'h8000_0008);
            check("t2_wdata", axi_wdata, 64'hDEADBEEF_CAFEF00D);
            check("t2_wstrb", axi_wstrb, 8'h0F);
            check("t2_wlast", axi_wlast, 1);
            tick();
        end
        axi_awready = 1'b0;
        axi_wready = 1'b0;
        check("t2_bready", axi_bready, 1);
        check("t2_w_dropped", axi_wvalid, 0);
        sb.push_back('{data: 64'h0, err: 1'b0});
        axi_bvalid = 1'b1;
        axi_bresp = 2'b00;
        tick();
        axi_bvalid = 1'b0;
        wait_rsp("t2", seen);
        check("t2_aw_beats", 64'(aw_hs - aw0), 1);
        check("t2_w_beats", 64'(w_hs - w0), 1);

        // 3: write, W accepted first, AW after three cycles, B after two more
        aw0 = aw_hs;
        w0 = w_hs;
        issue(64'h8000_0020, 1'b1, 64'h0123456789ABCDEF, 8'hFF, 3'd3);
        axi_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            axi_awready = (i == 3);
            check("t3_awvalid", axi_awvalid, 1);
            check("t3_wvalid", axi_wvalid, (i == 0) ? 1 : 0);
            tick();
        end
        axi_awready = 1'b0;
        axi_wready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t3_bready_wait", axi_bready, 1);
            check("t3_no_early_rsp", rsp_valid, 0);
            tick();
        end
        sb.push_back('{data: 64'h0, err: 1'b0});
        axi_bvalid = 1'b1;
        tick();
        axi_bvalid = 1'b0;
        wait_rsp("t3", seen);
        for (int i = 0; i < 3; i++) begin
            check("t3_no_dup_rsp", rsp_valid, 0);
            tick();
        end
        check("t3_aw_beats", 64'(aw_hs - aw0), 1);
        check("t3_w_beats", 64'(w_hs - w0), 1);

        // 4: read with AR backpressure and SLVERR
        ar0 = ar_hs;
        issue(64'h8000_0040, 1'b0, 64'h0, 8'h00, 3'd2);
        for (int i = 0; i < 6; i++) begin
            axi_arready = (i == 5);
            check("t4_arvalid", axi_arvalid, 1);
            check("t4_araddr", axi_araddr, 64'h8000_0040);
            check("t4_arsize", axi_arsize, 2);
            check("t4_busy", cmd_ready, 0);
            tick();
        end
        axi_arready = 1'b0;
        check("t4_ar_beats", 64'(ar_hs - ar0), 1);
        check("t4_rready", axi_rready, 1);
        sb.push_back('{data: 64'hA5A5_5A5A_0F0F_F0F0, err: 1'b1});
        axi_rvalid = 1'b1;
        axi_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
        axi_rresp = 2'b10;
        tick();
        axi_rvalid = 1'b0;
        axi_rresp = 2'b00;
        wait_rsp("t4", seen);

        // 5: cmd_valid held high across a read then a write
        sb.push_back('{data: 64'h5555_6666_7777_8888, err: 1'b0});
        cmd_valid = 1'b1;
        cmd_payload_addr = 64'h100;
        cmd_payload_wen = 1'b0;
        cmd_payload_size = 3'd3;
        check("t5_ready_first", cmd_ready, 1);
        tick();
        cmd_payload_addr = 64'h108;
        cmd_payload_wen = 1'b1;
        cmd_payload_wdata = 64'h0BAD_F00D_1234_5678;
        cmd_payload_wstrb = 8'hFF;
        check("t5_rd_araddr", axi_araddr, 64'h100);
        check("t5_no_aw_during_rd", axi_awvalid, 0);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        check("t5_no_aw_rdata", axi_awvalid, 0);
        axi_rvalid = 1'b1;
        axi_rdata = 64'h5555_6666_7777_8888;
        tick();
        axi_rvalid = 1'b0;
        wait_rsp("t5_rd", seen);
        sb.push_back('{data: 64'h0, err: 1'b0});
        check("t5_idle_no_aw", axi_awvalid, 0);
        tick();
        cmd_valid = 1'b0;
        check("t5_awvalid", axi_awvalid, 1);
        check("t5_awaddr", axi_awaddr, 64'h108);
        check("t5_wdata", axi_wdata, 64'h0BAD_F00D_1234_5678);
        axi_awready = 1'b1;
        axi_wready = 1'b1;
        tick();
        axi_awready = 1'b0;
        axi_wready = 1'b0;
        check("t5_bready", axi_bready, 1);
        axi_bvalid = 1'b1;
        tick();
        axi_bvalid = 1'b0;
        wait_rsp("t5_wr", seen);

        // 6: asynchronous reset while the write request is pending
        issue(64'h200, 1'b1, 64'hFFFF_0000_FFFF_0000, 8'hF0, 3'd3);
        check("t6_awvalid_pre", axi_awvalid, 1);
        check("t6_wvalid_pre", axi_wvalid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_awvalid", axi_awvalid, 0);
        check("t6_async_wvalid", axi_wvalid, 0);
        check("t6_async_rsp", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_ready_after_rst", cmd_ready, 1);
        tick();
        read_zero_wait("t6_rd", 64'h300, 64'hCAFE_BABE_0000_0001);

        check("sb_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
